// File: rtl/mem_bus_arbiter.sv
// Two-requester test-memory arbiter: DMA has fixed priority, and a
// starvation counter forces the CPU through after STARVE_LIMIT DMA wins.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic [1:0]        bus_owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    logic [3:0]        starve_cnt;
    logic              starved;
    logic [ADDR_W-1:0] addr;

    assign starved = (starve_cnt == LIMIT);

    // Grants are suppressed for the whole reset window so nothing is written.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            cpu_gnt = cpu_req & (~dma_req | starved);
            dma_gnt = dma_req & ~cpu_gnt;
        end
    end

    always_comb begin
        addr       = '0;
        mem_w_data = '0;
        mem_wen    = 1'b0;
        unique case (1'b1)
            cpu_gnt: begin
                addr       = cpu_addr;
                mem_w_data = cpu_wdata;
                mem_wen    = cpu_we;
            end
            dma_gnt: begin
                addr       = dma_addr;
                mem_w_data = dma_wdata;
                mem_wen    = dma_we;
            end
            default: ;
        endcase
    end

    assign mem_r_addr = addr;
    assign mem_w_addr = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_cnt <= '0;
        end else if (dma_gnt && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            bus_owner  <= OWN_NONE;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_r_data;
            if (dma_gnt && !dma_we) dma_rdata <= mem_r_data;
            unique case (1'b1)
                cpu_gnt: bus_owner <= OWN_CPU;
                dma_gnt: bus_owner <= OWN_DMA;
                default: bus_owner <= OWN_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural memory and
// per-requester read-data scoreboards.
module tb_mem_bus_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        mem_wen;
    logic [15:0] mem_r_addr, mem_w_addr;
    logic [7:0]  mem_w_data, mem_r_data;
    logic [1:0]  bus_owner;

    logic [7:0] mem  [0:255];
    logic [7:0] snap [0:255];

    logic [7:0] cpu_q[$];
    logic [7:0] dma_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_wen(mem_wen), .mem_r_addr(mem_r_addr),
        .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data), .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_r_addr[7:0]];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_w_addr[7:0]] <= mem_w_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Read-return scoreboard: every rvalid must match the oldest expectation.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
            else chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_q.pop_front()});
        end
        if (dma_rvalid) begin
            if (dma_q.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
            else chk("dma_rdata", {24'd0, dma_rdata}, {24'd0, dma_q.pop_front()});
        end
    end

    initial begin
        int     cnt;
        logic   exp_c;
        logic [1:0] prev;
        int     diffs;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h3E;
        mem[1] = 8'h10;
        mem[2] = 8'h06;
        mem[3] = 8'h20;

        // Reset with both requesters active
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0001; dma_wdata = 8'h00;
        repeat (2) begin
            @(negedge clk);
            chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 0);
            chk("rst_dma_gnt", {31'd0, dma_gnt}, 0);
            chk("rst_mem_wen", {31'd0, mem_wen}, 0);
            chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);
            chk("rst_owner", {30'd0, bus_owner}, 0);
        end
        tick;
        rst = 1'b0;

        // Both held: D,D,D,D,C repeating
        cnt  = 0;
        prev = 2'd0;
        for (int i = 0; i < 10; i++) begin
            exp_c = (cnt == LIM);
            if (exp_c) cpu_q.push_back(8'h3E);
            else dma_q.push_back(8'h10);
            @(negedge clk);
            chk($sformatf("starve_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, {31'd0, exp_c});
            chk($sformatf("starve_dma_gnt_%0d", i), {31'd0, dma_gnt}, {31'd0, ~exp_c});
            chk($sformatf("starve_cnt_%0d", i), {28'd0, dut.starve_cnt}, cnt);
            chk($sformatf("starve_owner_%0d", i), {30'd0, bus_owner}, {30'd0, prev});
            cnt  = exp_c ? 0 : ((cnt == LIM) ? LIM : cnt + 1);
            prev = exp_c ? 2'd1 : 2'd2;
            tick;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick;
        tick;

        // CPU write 0x20 <- 0x5A, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h5A;
        @(negedge clk);
        chk("wr_cpu_gnt", {31'd0, cpu_gnt}, 1);
        chk("wr_mem_wen", {31'd0, mem_wen}, 1);
        chk("wr_mem_w_addr", {16'd0, mem_w_addr}, 32'h20);
        chk("wr_mem_w_data", {24'd0, mem_w_data}, 32'h5A);
        tick;
        cpu_we = 1'b0;
        cpu_q.push_back(8'h5A);
        @(negedge clk);
        chk("rd_cpu_gnt", {31'd0, cpu_gnt}, 1);
        chk("rd_mem_wen", {31'd0, mem_wen}, 0);
        chk("wr_no_rvalid", {31'd0, cpu_rvalid}, 0);
        tick;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("mem_0x20", {24'd0, mem[8'h20]}, 32'h5A);
        tick;

        // CPU read of preloaded 0x0000
        cpu_req = 1'b1; cpu_addr = 16'h0000;
        cpu_q.push_back(8'h3E);
        @(negedge clk);
        chk("rd0_cpu_gnt", {31'd0, cpu_gnt}, 1);
        tick;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd0_cpu_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("rd0_dma_rvalid", {31'd0, dma_rvalid}, 0);
        chk("rd0_owner", {30'd0, bus_owner}, 1);
        tick;
        @(negedge clk);
        chk("rd0_rvalid_pulse", {31'd0, cpu_rvalid}, 0);
        chk("rd0_rdata_hold", {24'd0, cpu_rdata}, 32'h3E);
        chk("idle_owner", {30'd0, bus_owner}, 0);
        tick;

        // DMA pipelined reads 0..3
        dma_req = 1'b1; dma_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dma_addr = 16'(i);
            dma_q.push_back(i == 0 ? 8'h3E : i == 1 ? 8'h10 : i == 2 ? 8'h06 : 8'h20);
            @(negedge clk);
            chk($sformatf("dma_pipe_gnt_%0d", i), {31'd0, dma_gnt}, 1);
            if (i > 0) chk($sformatf("dma_pipe_rvalid_%0d", i), {31'd0, dma_rvalid}, 1);
            tick;
        end
        dma_req = 1'b0;
        @(negedge clk);
        chk("dma_pipe_rvalid_last", {31'd0, dma_rvalid}, 1);
        tick;

        // Reset pulse right after a CPU read grant; a write held during reset
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        @(negedge clk);
        chk("rp_cpu_gnt", {31'd0, cpu_gnt}, 1);
        tick;
        rst = 1'b1;
        cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 8'hFF;
        @(negedge clk);
        chk("rp_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("rp_mem_wen", {31'd0, mem_wen}, 0);
        chk("rp_cpu_gnt_rst", {31'd0, cpu_gnt}, 0);
        chk("rp_cnt", {28'd0, dut.starve_cnt}, 0);
        tick;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("rp_cpu_rvalid_after", {31'd0, cpu_rvalid}, 0);
        tick;
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
        chk("rp_mem_intact", diffs, 0);

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("dma_q_drained", dma_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
